mult_sequencer: RTL and testbench
=================================

// Module: mult_sequencer
// PURPOSE
//  Upstream control stage for the shift-add Multiplier. Accepts operand pairs over a valid/ready
//  handshake, registers them, pulses the multiplier's start, waits for finished, captures product
//  and holds it on a valid/ready output port. Adds a zero-operand bypass and a hang watchdog.
// PARAMETERS
//  N        8        operand width; product width is N+1, matching the multiplier
//  TIMEOUT  2*N+4    max cycles in WAIT before reporting error; must be >= 1
// PORTS
//  clock        in   1    single clock, rising edge
//  reset        in   1    asynchronous, active-low reset
//  in_valid     in   1    operand pair present
//  in_ready     out  1    sequencer can accept (high only in IDLE)
//  in_a         in   N    multiplicand
//  in_b         in   N    multiplier
//  mul_start    out  1    one-cycle start pulse to multiplier
//  mul_a        out  N    registered operand A to multiplier, stable from ISSUE through WAIT
//  mul_b        out  N    registered operand B to multiplier, stable from ISSUE through WAIT
//  mul_product  in   N+1  multiplier result
//  mul_finished in   1    multiplier done; sampled only in WAIT
//  out_valid    out  1    result held
//  out_ready    in   1    consumer takes result
//  out_product  out  N+1  result (0 on error or bypass)
//  out_error    out  1    watchdog expired; qualified by out_valid
//  busy         out  1    state != IDLE
// BEHAVIOUR
//  - Reset (async, reset==0): state=IDLE; in_ready=1 once reset released; mul_start=0;
//    mul_a=mul_b=0; out_valid=0; out_product=0; out_error=0; busy=0; watchdog count=0.
//  - States: IDLE, ISSUE, WAIT, HOLD.
//  - IDLE: in_ready=1. On in_valid&in_ready at edge t: latch in_a/in_b.
//    If in_a==0 or in_b==0 -> HOLD, out_product=0, out_error=0 (bypass, out_valid at t+1).
//    Else -> ISSUE.
//  - ISSUE: mul_start=1 for exactly this one cycle; watchdog cleared; -> WAIT.
//  - WAIT: mul_start=0; watchdog increments each cycle.
//    mul_finished==1 -> capture mul_product into out_product, out_error=0, -> HOLD
//    (finished has priority over watchdog expiry in the same cycle).
//    Else if count reaches TIMEOUT-1 -> out_product=0, out_error=1, -> HOLD.
//  - HOLD: out_valid=1; out_product/out_error stable. On out_ready -> IDLE.
//    out_ready while out_valid=0 is ignored; no new operands accepted until HOLD exits
//    (one bubble cycle in IDLE between operations; no same-cycle re-accept).
//  - mul_finished outside WAIT ignored; in_valid outside IDLE ignored (in_ready=0, no latch).
//  - Widths: out_product is N+1 bits, copied unmodified; no truncation or sign handling (unsigned).
//  - Watchdog counter width clog2(TIMEOUT+1); saturates, never wraps.
//  - Reset asserted mid-operation: immediate return to reset values; in-flight result discarded;
//    mul_start never glitches high.
//  - Latency (nonzero operands): accept at t, mul_start at t+1, finished seen at t+1+k,
//    out_valid at t+2+k.
// STRUCTURE
//  - Shared include alu_defs.vh: state encodings (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, HOLD=2'd3),
//    default N, clog2 helper macro.
//  - One sub-module: wdog_counter (clear, enable, terminal-count output, parameter TIMEOUT).
//  - All outputs registered except in_ready and busy (decoded from state register).
// TESTING (N=8 unless stated; multiplier bench-modelled or instantiated)
//  - Basic: in_a=13, in_b=11 -> one mul_start pulse, out_product=9'h08F, out_error=0,
//    out_valid until out_ready.
//  - Zero bypass: in_a=0, in_b=200 -> no mul_start, out_valid 1 cycle after accept,
//    out_product=0.
//  - Timeout: model never asserts finished, TIMEOUT=20 -> out_error=1, out_product=0,
//    out_valid exactly 20 cycles after start pulse.
//  - Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 -> in_ready stays 0,
//    out_product unchanged; release -> IDLE, next pair accepted one cycle later.
//  - Race: finished and watchdog terminal count in same cycle -> out_error=0,
//    product captured.
//  - Reset mid-WAIT: drop reset for 1 cycle -> all outputs to reset values asynchronously;
//    later finished ignored; new 255*255 -> out_product=9'h001 (low N+1 bits of the
//    multiplier's output, passed through unmodified).

Source files
------------

// File: rtl/mult_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_sequencer_pkg
//  Description : Shared types and helpers for the multiplier sequencer:
//                state encoding, default operand width, clog2 helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_sequencer_pkg;

  localparam int DEFAULT_N = 8;
  localparam int STATE_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  // Width needed to hold 'value' distinct states, never less than one bit.
  function automatic int clog2_safe(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wdog_counter.sv
`default_nettype none
// ============================================================================
//  Module      : wdog_counter
//  Description : Saturating hang watchdog. Cleared on request, counts while
//                enabled, flags terminal count at TIMEOUT-1.
//  Revision    : 1.0 - initial release
// ============================================================================
module wdog_counter
  import mult_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int               CNT_W    = clog2_safe(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] TC_VALUE = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // Cycle counter: clear wins, then saturating increment while enabled
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

  // Greater-or-equal keeps the flag asserted if the count ever runs past
  assign terminal = (count >= TC_VALUE);

endmodule
`default_nettype wire

// File: rtl/mult_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mult_sequencer
//  Description : Control stage in front of a shift-add multiplier. Accepts an
//                operand pair, pulses start, waits for finished (guarded by a
//                watchdog), then holds the product on a valid/ready port.
//                Zero operands bypass the multiplier entirely.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_sequencer
  import mult_sequencer_pkg::*;
#(
  parameter int N       = DEFAULT_N,
  parameter int TIMEOUT = 2*N + 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic         mul_start,
  output logic [N-1:0] mul_a,
  output logic [N-1:0] mul_b,
  input  logic [N:0]   mul_product,
  input  logic         mul_finished,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   out_product,
  output logic         out_error,
  output logic         busy
);

  state_e state;
  state_e state_next;
  logic   accept;
  logic   zero_op;
  logic   wdog_tc;

  assign accept  = (state == ST_IDLE) && in_valid;
  assign zero_op = (in_a == '0) || (in_b == '0);

  // The watchdog is zeroed at accept so it reads zero throughout ISSUE;
  // counting from ISSUE onward makes the first WAIT cycle read one, so the
  // timeout fires exactly TIMEOUT cycles after the start pulse.
  wdog_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clock    (clock),
    .reset    (reset),
    .clear    (accept),
    .enable   ((state == ST_ISSUE) || (state == ST_WAIT)),
    .terminal (wdog_tc)
  );

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; finished takes priority over watchdog expiry
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (in_valid) state_next = zero_op ? ST_HOLD : ST_ISSUE;
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT:  if (mul_finished || wdog_tc) state_next = ST_HOLD;
      ST_HOLD:  if (out_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Handshake/status outputs decoded straight from the state register
  always_comb begin
    in_ready = (state == ST_IDLE);
    busy     = (state != ST_IDLE);
  end

  // Registered datapath outputs: operands, start pulse, result and flags
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mul_start   <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      out_valid   <= 1'b0;
      out_product <= '0;
      out_error   <= 1'b0;
    end else begin
      mul_start <= accept && !zero_op;
      out_valid <= (state_next == ST_HOLD);
      if (accept) begin
        mul_a <= in_a;
        mul_b <= in_b;
      end
      case (state)
        ST_IDLE: begin
          if (accept && zero_op) begin
            out_product <= '0;
            out_error   <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (mul_finished) begin
            out_product <= mul_product;
            out_error   <= 1'b0;
          end else if (wdog_tc) begin
            out_product <= '0;
            out_error   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_sequencer
//  Description : Self-checking bench for mult_sequencer with a behavioural
//                multiplier and a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_sequencer;

  localparam int N = 8;
  localparam int T = 20;

  typedef logic [N-1:0] op_t;
  typedef logic [N:0]   prod_t;

  logic  clock = 1'b0;
  logic  reset = 1'b0;
  logic  in_valid = 1'b0;
  logic  in_ready;
  op_t   in_a = '0;
  op_t   in_b = '0;
  logic  mul_start;
  op_t   mul_a;
  op_t   mul_b;
  prod_t mul_product = '0;
  logic  mul_finished = 1'b0;
  logic  out_valid;
  logic  out_ready = 1'b0;
  prod_t out_product;
  logic  out_error;
  logic  busy;

  int    n_tests = 0;
  int    n_fail  = 0;
  prod_t last_prod;

  mult_sequencer #(
    .N       (N),
    .TIMEOUT (T)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .mul_start    (mul_start),
    .mul_a        (mul_a),
    .mul_b        (mul_b),
    .mul_product  (mul_product),
    .mul_finished (mul_finished),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_product  (out_product),
    .out_error    (out_error),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Unsigned product truncated to N+1 bits, as the multiplier delivers it
  function automatic prod_t ref_product(input op_t a, input op_t b);
    logic [2*N-1:0] full;
    full = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    return full[N:0];
  endfunction

  // Cycles after the accept edge at which out_valid is first seen.
  // lat = WAIT cycle (1-based) in which finished is raised; 0 = never.
  function automatic int ref_valid_cycle(input logic bypass, input int lat);
    if (bypass) return 0;
    if (lat >= 1 && lat <= T-1) return lat + 1;
    return T;
  endfunction

  task automatic run_op(input op_t a, input op_t b, input int lat, input int hold_cycles);
    logic  bypass;
    logic  done_ok;
    int    e;
    int    guard;
    prod_t exp_p;
    logic  exp_e;

    bypass  = (a == '0) || (b == '0);
    e       = ref_valid_cycle(bypass, lat);
    done_ok = !bypass && (lat >= 1) && (lat <= T-1);
    exp_p   = done_ok ? ref_product(a, b) : '0;
    exp_e   = !bypass && !done_ok;

    guard = 0;
    while (in_ready !== 1'b1 && guard < 8) begin
      @(negedge clock);
      guard++;
    end
    check("in_ready_idle", 32'(in_ready), 32'(1));

    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(posedge clock);

    for (int c = 0; c <= e; c++) begin
      #1;
      in_valid  = 1'b0;
      in_a      = op_t'($urandom);
      in_b      = op_t'($urandom);
      out_ready = (c < e) ? 1'($urandom) : 1'b0;
      if (!bypass && c == lat) begin
        mul_finished = 1'b1;
        mul_product  = ref_product(a, b);
      end else if (c == 0 && !bypass) begin
        mul_finished = 1'($urandom);
        mul_product  = prod_t'($urandom);
      end else begin
        mul_finished = 1'b0;
        mul_product  = prod_t'($urandom);
      end
      @(negedge clock);
      check("out_valid_timing", 32'(out_valid), 32'(c >= e));
      check("mul_start", 32'(mul_start), 32'((c == 0) && !bypass));
      check("in_ready_busy", 32'(in_ready), 32'(0));
      check("busy", 32'(busy), 32'(1));
      if (c == 0) begin
        check("mul_a", 32'(mul_a), 32'(a));
        check("mul_b", 32'(mul_b), 32'(b));
      end
      if (c < e) @(posedge clock);
    end
    check("out_product", 32'(out_product), 32'(exp_p));
    check("out_error", 32'(out_error), 32'(exp_e));
    last_prod = out_product;

    // Backpressure: result must hold, new operands must be refused
    for (int h = 0; h < hold_cycles; h++) begin
      @(posedge clock);
      #1;
      in_valid     = 1'b1;
      in_a         = op_t'($urandom);
      in_b         = op_t'($urandom);
      mul_finished = 1'($urandom);
      mul_product  = prod_t'($urandom);
      out_ready    = 1'b0;
      @(negedge clock);
      check("hold_in_ready", 32'(in_ready), 32'(0));
      check("hold_valid", 32'(out_valid), 32'(1));
      check("hold_product", 32'(out_product), 32'(exp_p));
      check("hold_error", 32'(out_error), 32'(exp_e));
    end

    out_ready    = 1'b1;
    in_valid     = 1'b0;
    mul_finished = 1'b0;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    @(negedge clock);
    check("release_valid", 32'(out_valid), 32'(0));
    check("release_in_ready", 32'(in_ready), 32'(1));
    check("release_busy", 32'(busy), 32'(0));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'(0));
    check({tag, "_mul_start"}, 32'(mul_start), 32'(0));
    check({tag, "_mul_a"}, 32'(mul_a), 32'(0));
    check({tag, "_mul_b"}, 32'(mul_b), 32'(0));
    check({tag, "_out_product"}, 32'(out_product), 32'(0));
    check({tag, "_out_error"}, 32'(out_error), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    op_t a;
    op_t b;

    #2;
    check_reset_values("reset");
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("in_ready_after_reset", 32'(in_ready), 32'(1));

    // Basic product
    run_op(8'd13, 8'd11, 4, 2);
    check("basic_13x11", 32'(last_prod), 32'(9'h08F));
    // Zero bypass
    run_op(8'd0, 8'd200, 3, 1);
    check("bypass_zero", 32'(last_prod), 32'(0));
    // Timeout: finished never raised
    run_op(8'd77, 8'd5, 0, 1);
    // Backpressure for 10 cycles, then immediate next pair
    run_op(8'd21, 8'd9, 6, 10);
    run_op(8'd2, 8'd3, 1, 0);
    // Finished coincides with watchdog terminal count
    run_op(8'd3, 8'd7, T-1, 0);
    // Finished one cycle too late lands in HOLD and is ignored
    run_op(8'd40, 8'd6, T, 0);

    // Reset dropped mid-WAIT
    in_valid = 1'b1;
    in_a     = 8'd100;
    in_b     = 8'd3;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("midwait");
    @(posedge clock);
    #1;
    check("midwait_start_low", 32'(mul_start), 32'(0));
    @(negedge clock);
    reset        = 1'b1;
    mul_finished = 1'b1;
    mul_product  = 9'h1AB;
    @(posedge clock);
    #1;
    mul_finished = 1'b0;
    @(negedge clock);
    check("late_finished_valid", 32'(out_valid), 32'(0));
    check("late_finished_busy", 32'(busy), 32'(0));
    run_op(8'd255, 8'd255, 3, 1);
    check("prod_255x255", 32'(last_prod), 32'(9'h001));

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      a = op_t'($urandom);
      b = op_t'($urandom);
      if ($urandom_range(0, 4) == 0) a = '0;
      if ($urandom_range(0, 6) == 0) b = '0;
      run_op(a, b, int'($urandom_range(0, T+1)), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
